// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter with per-register pending-write scoreboard; optional forwarding via WB_FWD_EN
module wb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int PEND_W  = 2,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_SRC-1:0]      src_valid,
  output logic [NUM_SRC-1:0]      src_ready,
  input  logic [NUM_SRC*5-1:0]    src_rd_addr,
  input  logic [NUM_SRC*XLEN-1:0] src_rd_data,
  input  logic                    sb_set_en,
  input  logic [4:0]              sb_set_addr,
  output logic                    sb_set_ready,
  input  logic [4:0]              rs1_addr,
  input  logic [4:0]              rs2_addr,
  input  logic                    rs1_rd_en,
  input  logic                    rs2_rd_en,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic [4:0]              rd_addr,
  output logic [XLEN-1:0]         rd_data,
  output logic                    rd_wr_en,
  output logic                    fwd_valid,
  output logic [4:0]              fwd_addr,
  output logic [XLEN-1:0]         fwd_data
);
  localparam int PTR_W = $clog2(NUM_SRC);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gidx;
  logic [PTR_W-1:0]  cand [NUM_SRC];
  logic [4:0]        addr_a [NUM_SRC];
  logic [XLEN-1:0]   data_a [NUM_SRC];
  logic              xfer;
  logic [4:0]        sel_addr;
  logic [XLEN-1:0]   sel_data;
  logic [PEND_W-1:0] cnt [32];
  logic [31:0]       set_vec;
  logic [31:0]       clr_vec;
  logic              hit1;
  logic              hit2;
  genvar i;
  generate
    for (i = 0; i < NUM_SRC; i++) begin : g_src
      assign addr_a[i] = src_rd_addr[5*i +: 5];
      assign data_a[i] = src_rd_data[XLEN*i +: XLEN];
      assign cand[i]   = PTR_W'((int'(rr_ptr) + i) % NUM_SRC);
    end
  endgenerate
  // pick the first valid source at or after rr_ptr; the grant doubles as ready
  always_comb begin
    src_ready = '0;
    gidx      = '0;
    xfer      = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!xfer && src_valid[cand[k]]) begin
        xfer              = 1'b1;
        src_ready[cand[k]] = 1'b1;
        gidx              = cand[k];
      end
    end
  end
  assign sel_addr = addr_a[gidx];
  assign sel_data = data_a[gidx];
  // registered write port; x0 results are consumed without a write, pointer moves past the winner
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_wr_en <= 1'b0;
      rd_addr  <= '0;
      rd_data  <= '0;
      rr_ptr   <= '0;
    end else begin
      rd_wr_en <= xfer && (sel_addr != 5'd0);
      if (xfer) begin
        rd_addr <= sel_addr;
        rd_data <= sel_data;
        rr_ptr  <= (gidx == PTR_W'(NUM_SRC - 1)) ? '0 : gidx + 1'b1;
      end
    end
  end
  assign sb_set_ready = cnt[sb_set_addr] != CNT_MAX;
  // one-hot set/clear requests per register; saturated sets are dropped
  always_comb begin
    set_vec = (sb_set_en && sb_set_ready && sb_set_addr != 5'd0) ? (32'd1 << sb_set_addr) : 32'd0;
    clr_vec = rd_wr_en ? (32'd1 << rd_addr) : 32'd0;
  end
  // pending-write counters; simultaneous set and clear cancel, decrement never wraps below zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (set_vec[r] && !clr_vec[r]) cnt[r] <= cnt[r] + 1'b1;
        else if (clr_vec[r] && !set_vec[r] && cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end
  // forwarding of the committing write and busy suppression on its last outstanding write
  always_comb begin
`ifdef WB_FWD_EN
    fwd_valid = rd_wr_en;
    fwd_addr  = rd_addr;
    fwd_data  = rd_data;
    hit1      = rd_wr_en && rd_addr == rs1_addr && cnt[rs1_addr] == CNT_ONE;
    hit2      = rd_wr_en && rd_addr == rs2_addr && cnt[rs2_addr] == CNT_ONE;
`else
    fwd_valid = 1'b0;
    fwd_addr  = '0;
    fwd_data  = '0;
    hit1      = 1'b0;
    hit2      = 1'b0;
`endif
    rs1_busy = rs1_rd_en && cnt[rs1_addr] != '0 && !hit1;
    rs2_busy = rs2_rd_en && cnt[rs2_addr] != '0 && !hit2;
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard-driven bench for wb_arbiter (default build or with WB_FWD_EN)
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [14:0] src_rd_addr;
  logic [95:0] src_rd_data;
  logic        sb_set_en;
  logic [4:0]  sb_set_addr;
  logic        sb_set_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_rd_en, rs2_rd_en;
  logic        rs1_busy, rs2_busy;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_wr_en;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic [36:0] exp_q [$];
  logic [36:0] mon_exp;

  wb_arbiter #(.NUM_SRC(3), .PEND_W(2), .XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .src_valid(src_valid), .src_ready(src_ready),
    .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_set_ready(sb_set_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_rd_en(rs1_rd_en), .rs2_rd_en(rs2_rd_en),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_wr_en(rd_wr_en),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rstn && mon_en && rd_wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got addr=%0d data=%h expected no write", rd_addr, rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rd_addr, rd_data} !== mon_exp) begin
          errors++;
          $display("FAIL wr_data got addr=%0d data=%h expected addr=%0d data=%h",
                   rd_addr, rd_data, mon_exp[36:32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    src_valid[i] = v;
    src_rd_addr[i*5 +: 5] = a;
    src_rd_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset;
    src_valid = '0;
    sb_set_en = 1'b0;
    rstn = 1'b0;
    tick;
    rstn = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    tick;
    tick;
    checks++; if (rd_wr_en !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0) begin errors++; $display("FAIL reset_state got en=%b addr=%0d data=%h expected 0", rd_wr_en, rd_addr, rd_data); end
    rstn = 1'b1;
    mon_en = 1'b0;
    sb_set_en = 1'b1; sb_set_addr = 5'd1;
    set_src(0, 1'b1, 5'd1, 32'h0000_AAAA);
    tick;
    sb_set_en = 1'b0;
    checks++; if (rd_wr_en !== 1'b1) begin errors++; $display("FAIL burst_write got %b expected 1", rd_wr_en); end
    #2 rstn = 1'b0;
    #1;
    rs1_addr = 5'd1;
    #1;
    checks++; if (rd_wr_en !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0) begin errors++; $display("FAIL reset_mid got en=%b addr=%0d data=%h expected 0", rd_wr_en, rd_addr, rd_data); end
    checks++; if (fwd_valid !== 1'b0 || fwd_addr !== 5'd0 || fwd_data !== 32'd0) begin errors++; $display("FAIL reset_fwd got v=%b a=%0d d=%h expected 0", fwd_valid, fwd_addr, fwd_data); end
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", rs1_busy); end
    src_valid = '0;
    tick;
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++; if (rd_wr_en !== 1'b0 || src_ready !== 3'b000) begin errors++; $display("FAIL idle got en=%b ready=%b expected 0", rd_wr_en, src_ready); end
    end
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      #0.1;
      checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL idle_busy x%0d got %b expected 0", a, rs1_busy); end
    end
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_single_write;
    sb_set_en = 1'b1; sb_set_addr = 5'd5;
    tick;
    sb_set_en = 1'b0;
    rs1_addr = 5'd5;
    #1;
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL set_busy got %b expected 1", rs1_busy); end
    set_src(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    checks++; if (src_ready !== 3'b001) begin errors++; $display("FAIL single_ready got %b expected 001", src_ready); end
    exp_q.push_back({5'd5, 32'hDEAD_BEEF});
    tick;
    src_valid = '0;
    checks++; if (rd_wr_en !== 1'b1) begin errors++; $display("FAIL single_en got %b expected 1", rd_wr_en); end
`ifdef WB_FWD_EN
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL commit_busy got %b expected 0", rs1_busy); end
`else
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL commit_busy got %b expected 1", rs1_busy); end
`endif
    tick;
    checks++; if (rs1_busy !== 1'b0 || rd_wr_en !== 1'b0) begin errors++; $display("FAIL after_write got busy=%b en=%b expected 0 0", rs1_busy, rd_wr_en); end
  endtask

  task automatic test_round_robin;
    int rr_exp [4] = '{0, 1, 2, 0};
    int g;
    do_reset;
    for (int s = 0; s < 3; s++) set_src(s, 1'b1, 5'(s + 1), 32'hC000_0000 + 32'(s));
    for (int c = 0; c < 4; c++) begin
      g = rr_exp[c];
      #1;
      checks++; if (src_ready !== 3'(1 << g)) begin errors++; $display("FAIL rr_grant%0d got %b expected %b", c, src_ready, 3'(1 << g)); end
      exp_q.push_back({5'(g + 1), src_rd_data[g*32 +: 32]});
      tick;
      checks++; if (rd_wr_en !== 1'b1 || rd_addr !== 5'(g + 1)) begin errors++; $display("FAIL rr_addr%0d got en=%b addr=%0d expected 1 %0d", c, rd_wr_en, rd_addr, g + 1); end
      set_src(g, 1'b1, 5'(g + 1), 32'hB000_0000 + 32'(c * 16 + g));
    end
    src_valid = '0;
    tick;
  endtask

  task automatic test_x0_write;
    set_src(2, 1'b1, 5'd0, 32'h0000_1234);
    sb_set_en = 1'b1; sb_set_addr = 5'd0;
    #1;
    checks++; if (src_ready !== 3'b100) begin errors++; $display("FAIL x0_ready got %b expected 100", src_ready); end
    checks++; if (sb_set_ready !== 1'b1) begin errors++; $display("FAIL x0_set_ready got %b expected 1", sb_set_ready); end
    tick;
    src_valid = '0;
    sb_set_en = 1'b0;
    rs1_addr = 5'd0;
    #1;
    checks++; if (rd_wr_en !== 1'b0) begin errors++; $display("FAIL x0_en got %b expected 0", rd_wr_en); end
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_busy got %b expected 0", rs1_busy); end
    tick;
  endtask

  task automatic write_x7(input logic [31:0] d);
    set_src(1, 1'b1, 5'd7, d);
    exp_q.push_back({5'd7, d});
    tick;
    src_valid = '0;
    tick;
  endtask

  task automatic test_saturation;
    rs1_addr = 5'd7;
    sb_set_addr = 5'd7;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (sb_set_ready !== 1'b1) begin errors++; $display("FAIL sat_ready%0d got %b expected 1", c, sb_set_ready); end
      sb_set_en = 1'b1;
      tick;
      sb_set_en = 1'b0;
    end
    #1;
    checks++; if (sb_set_ready !== 1'b0) begin errors++; $display("FAIL sat_full got %b expected 0", sb_set_ready); end
    sb_set_en = 1'b1;
    tick;
    sb_set_en = 1'b0;
    #1;
    checks++; if (sb_set_ready !== 1'b0 || rs1_busy !== 1'b1) begin errors++; $display("FAIL sat_nowrap got ready=%b busy=%b expected 0 1", sb_set_ready, rs1_busy); end
    write_x7(32'h7000_0001);
    checks++; if (rs1_busy !== 1'b1 || sb_set_ready !== 1'b1) begin errors++; $display("FAIL sat_w1 got busy=%b ready=%b expected 1 1", rs1_busy, sb_set_ready); end
    write_x7(32'h7000_0002);
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sat_w2 got %b expected 1", rs1_busy); end
    write_x7(32'h7000_0003);
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sat_w3 got %b expected 0", rs1_busy); end
    sb_set_en = 1'b1;
    tick;
    sb_set_en = 1'b0;
    set_src(1, 1'b1, 5'd7, 32'h7000_0004);
    exp_q.push_back({5'd7, 32'h7000_0004});
    tick;
    src_valid = '0;
    sb_set_en = 1'b1;
    tick;
    sb_set_en = 1'b0;
    #1;
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL setclr_hold got %b expected 1", rs1_busy); end
    write_x7(32'h7000_0005);
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL setclr_drain got %b expected 0", rs1_busy); end
  endtask

  task automatic test_forward;
    rs2_addr = 5'd9;
    sb_set_en = 1'b1; sb_set_addr = 5'd9;
    tick;
    sb_set_en = 1'b0;
    set_src(0, 1'b1, 5'd9, 32'h0000_0055);
    exp_q.push_back({5'd9, 32'h0000_0055});
    tick;
    src_valid = '0;
`ifdef WB_FWD_EN
    checks++; if (rs2_busy !== 1'b0) begin errors++; $display("FAIL fwd_busy got %b expected 0", rs2_busy); end
    checks++; if (fwd_valid !== 1'b1 || fwd_addr !== 5'd9 || fwd_data !== 32'h55) begin errors++; $display("FAIL fwd_data got v=%b a=%0d d=%h expected 1 9 55", fwd_valid, fwd_addr, fwd_data); end
`else
    checks++; if (rs2_busy !== 1'b1) begin errors++; $display("FAIL fwd_busy got %b expected 1", rs2_busy); end
    checks++; if (fwd_valid !== 1'b0 || fwd_addr !== 5'd0 || fwd_data !== 32'd0) begin errors++; $display("FAIL fwd_data got v=%b a=%0d d=%h expected 0 0 0", fwd_valid, fwd_addr, fwd_data); end
`endif
    tick;
    checks++; if (rs2_busy !== 1'b0) begin errors++; $display("FAIL fwd_after got %b expected 0", rs2_busy); end
  endtask

  initial begin
    src_valid = '0;
    src_rd_addr = '0;
    src_rd_data = '0;
    sb_set_en = 1'b0;
    sb_set_addr = '0;
    rs1_addr = '0;
    rs2_addr = '0;
    rs1_rd_en = 1'b1;
    rs2_rd_en = 1'b1;
    test_reset;
    test_single_write;
    test_round_robin;
    test_x0_write;
    test_saturation;
    test_forward;
    tick;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drain got %0d pending expected 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
